// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver family.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK_WAIT
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // s counter must reach SB_TICK-1 (up to 31); n counter must reach DBIT-1 (up to 8)
  localparam int S_W = 5;
  localparam int N_W = 4;

  function automatic bit sb_tick_legal(input int sb);
    return (sb == 16) || (sb == 24) || (sb == 32);
  endfunction

  function automatic bit dbit_legal(input int dbit);
    return (dbit >= 5) && (dbit <= 9);
  endfunction

  function automatic bit parity_legal(input int par);
    return (par == PAR_NONE) || (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// 16x oversampling UART receiver with majority-vote bit decisions, optional parity,
// framing/break/overrun detection and a one-deep holding register popped by rd.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int PARITY  = 0,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd,
  output logic [DBIT-1:0] dout,
  output logic            valid,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            overrun_err
);

  if (!sb_tick_legal(SB_TICK)) begin : g_bad_sb_tick
    $error("uart_rx_frame: SB_TICK must be 16, 24 or 32");
  end
  if (!dbit_legal(DBIT)) begin : g_bad_dbit
    $error("uart_rx_frame: DBIT must be 5..9");
  end
  if (!parity_legal(PARITY)) begin : g_bad_parity
    $error("uart_rx_frame: PARITY must be 0, 1 or 2");
  end

  localparam logic [S_W-1:0] S_MID  = S_W'(7);
  localparam logic [S_W-1:0] S_V0   = S_W'(13);
  localparam logic [S_W-1:0] S_V1   = S_W'(14);
  localparam logic [S_W-1:0] S_V2   = S_W'(15);
  localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
  localparam bit             HAS_PAR = (PARITY != PAR_NONE);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_expected(input logic [DBIT-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx_i  (rx),
    .rx_o  (rx_s)
  );

  state_e          state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] data_q, data_d;
  logic [1:0]      smp_q, smp_d;
  logic            par_bit_q, par_bit_d;
  logic            par_err_q, par_err_d;
  logic            stop_q, stop_d;

  logic            vote_c;
  logic            stop_c;
  logic            complete_c;
  logic            break_c;

  logic [DBIT-1:0] dout_q;
  logic            valid_q;
  logic            done_q;
  logic            perr_q;
  logic            ferr_q;
  logic            brk_q;
  logic            ovr_q;

  // Bit decision uses the two latched samples plus the live sample at s==15
  assign vote_c  = maj3(smp_q[0], smp_q[1], rx_s);
  assign stop_c  = (s_q == S_V2) ? rx_s : stop_q;
  assign break_c = ~stop_c && (data_q == '0) && (!HAS_PAR || !par_bit_q);

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    data_d     = data_q;
    smp_d      = smp_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    stop_d     = stop_q;
    complete_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_DATA;
              s_d       = '0;
              n_d       = '0;
              par_err_d = 1'b0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_V2) begin
            data_d = {vote_c, data_q[DBIT-1:1]};
            s_d    = '0;
            if (n_q == N_LAST) begin
              state_d = HAS_PAR ? ST_PAR : ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            if (s_q == S_V0) smp_d[0] = rx_s;
            if (s_q == S_V1) smp_d[1] = rx_s;
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_PAR: begin
        if (s_tick) begin
          if (s_q == S_V2) begin
            par_bit_d = vote_c;
            par_err_d = (vote_c != par_expected(data_q));
            state_d   = ST_STOP;
            s_d       = '0;
          end else begin
            if (s_q == S_V0) smp_d[0] = rx_s;
            if (s_q == S_V1) smp_d[1] = rx_s;
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_V2) stop_d = rx_s;
          if (s_q == S_LAST) begin
            complete_c = 1'b1;
            s_d        = '0;
            state_d    = (!stop_c && (data_q == '0)) ? ST_BRK_WAIT : ST_IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_BRK_WAIT: begin
        if (rx_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      par_err_q <= par_err_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q    <= data_d;
    smp_q     <= smp_d;
    par_bit_q <= par_bit_d;
    stop_q    <= stop_d;
  end

  // Holding register: a completing frame always wins; overrun records that an unread word was lost
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= complete_c;
      if (complete_c) begin
        dout_q  <= data_q;
        valid_q <= 1'b1;
        perr_q  <= HAS_PAR && par_err_q;
        ferr_q  <= ~stop_c;
        brk_q   <= break_c;
        ovr_q   <= valid_q && !rd;
      end else if (rd && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign break_det    = brk_q;
  assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: DBIT=8, even parity, one stop bit, s_tick every 4 clk.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       rx     = 1'b1;
  logic       s_tick = 1'b0;
  logic       rd     = 1'b0;
  logic [7:0] dout;
  logic       valid, rx_done_tick, parity_err, frame_err, break_det, overrun_err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  uart_rx_frame #(.DBIT(8), .PARITY(1), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rd           (rd),
    .dout         (dout),
    .valid        (valid),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .overrun_err  (overrun_err)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      s_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  always @(posedge clk) if (rx_done_tick === 1'b1) done_cnt <= done_cnt + 1;

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic st);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLK);
    hold(p, BIT_CLK);
    hold(st, BIT_CLK);
    hold(1'b1, BIT_CLK);
  endtask

  task automatic do_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({dout, valid, rx_done_tick, parity_err, frame_err, break_det, overrun_err} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%h flags=%b required all 0", dout,
               {valid, rx_done_tick, parity_err, frame_err, break_det, overrun_err});
    end
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got done_cnt=%0d valid=%b required 0 0", done_cnt, valid);
    end
  endtask

  task automatic test_basic();
    int c0;
    c0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    checks++;
    if (done_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses required 1", done_cnt - c0);
    end
    checks++;
    if (dout !== 8'h55) begin
      errors++;
      $display("FAIL basic_dout: got %h required 55", dout);
    end
    checks++;
    if ({valid, parity_err, frame_err, break_det, overrun_err} !== 5'b10000) begin
      errors++;
      $display("FAIL basic_flags: got %b required 10000",
               {valid, parity_err, frame_err, break_det, overrun_err});
    end
    do_rd();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd_valid: got %b required 0", valid);
    end
  endtask

  task automatic test_parity();
    int c0;
    c0 = done_cnt;
    send_frame(8'hA3, 1'b1, 1'b1);
    checks++;
    if (done_cnt - c0 !== 1 || dout !== 8'hA3) begin
      errors++;
      $display("FAIL parity_word: got pulses=%0d dout=%h required 1 a3", done_cnt - c0, dout);
    end
    checks++;
    if ({valid, parity_err, frame_err, break_det, overrun_err} !== 5'b11000) begin
      errors++;
      $display("FAIL parity_flags: got %b required 11000",
               {valid, parity_err, frame_err, break_det, overrun_err});
    end
    do_rd();
  endtask

  task automatic test_start_glitch();
    int c0;
    c0 = done_cnt;
    hold(1'b0, 12);
    hold(1'b1, BIT_CLK * 3);
    checks++;
    if (done_cnt !== c0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_done: got pulses=%0d valid=%b required 0 0", done_cnt - c0, valid);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL glitch_state: got %0d required %0d", dut.state_q, ST_IDLE);
    end
  endtask

  task automatic test_majority();
    logic [7:0] d;
    d = 8'h3C;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        hold(d[i], 28);
        hold(~d[i], 4);
        hold(d[i], BIT_CLK - 32);
      end else begin
        hold(d[i], BIT_CLK);
      end
    end
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK * 2);
    checks++;
    if (dout !== 8'h3C) begin
      errors++;
      $display("FAIL majority_dout: got %h required 3c", dout);
    end
    checks++;
    if ({valid, parity_err, frame_err, break_det, overrun_err} !== 5'b10000) begin
      errors++;
      $display("FAIL majority_flags: got %b required 10000",
               {valid, parity_err, frame_err, break_det, overrun_err});
    end
    do_rd();
  endtask

  task automatic test_break();
    int c0;
    c0 = done_cnt;
    hold(1'b0, BIT_CLK * 20);
    checks++;
    if (done_cnt - c0 !== 1 || dout !== 8'h00) begin
      errors++;
      $display("FAIL break_word: got pulses=%0d dout=%h required 1 00", done_cnt - c0, dout);
    end
    checks++;
    if ({valid, parity_err, frame_err, break_det, overrun_err} !== 5'b10110) begin
      errors++;
      $display("FAIL break_flags: got %b required 10110",
               {valid, parity_err, frame_err, break_det, overrun_err});
    end
    checks++;
    if (dut.state_q !== ST_BRK_WAIT) begin
      errors++;
      $display("FAIL break_state: got %0d required %0d", dut.state_q, ST_BRK_WAIT);
    end
    do_rd();
    hold(1'b1, BIT_CLK);
    send_frame(8'h12, 1'b0, 1'b1);
    checks++;
    if (done_cnt - c0 !== 2 || dout !== 8'h12) begin
      errors++;
      $display("FAIL break_recover: got pulses=%0d dout=%h required 2 12", done_cnt - c0, dout);
    end
    checks++;
    if ({valid, parity_err, frame_err, break_det, overrun_err} !== 5'b10000) begin
      errors++;
      $display("FAIL break_recover_flags: got %b required 10000",
               {valid, parity_err, frame_err, break_det, overrun_err});
    end
    do_rd();
  endtask

  task automatic test_overrun();
    int  c0;
    bit  hit;
    c0 = done_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    checks++;
    if (done_cnt - c0 !== 2 || dout !== 8'h22) begin
      errors++;
      $display("FAIL overrun_word: got pulses=%0d dout=%h required 2 22", done_cnt - c0, dout);
    end
    checks++;
    if ({valid, parity_err, frame_err, break_det, overrun_err} !== 5'b10001) begin
      errors++;
      $display("FAIL overrun_flags: got %b required 10001",
               {valid, parity_err, frame_err, break_det, overrun_err});
    end
    do_rd();
    checks++;
    if ({valid, overrun_err} !== 2'b00) begin
      errors++;
      $display("FAIL overrun_rd: got valid=%b ovr=%b required 0 0", valid, overrun_err);
    end

    send_frame(8'h11, 1'b0, 1'b1);
    hit = 1'b0;
    fork
      send_frame(8'h22, 1'b0, 1'b1);
      begin
        for (int k = 0; k < BIT_CLK * 12; k++) begin
          @(negedge clk);
          #1;
          if (dut.complete_c === 1'b1) begin
            rd = 1'b1;
            @(posedge clk);
            #1;
            rd = 1'b0;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL overrun_rd_same_clk: completion not seen within %0d clk", BIT_CLK * 12);
    end
    checks++;
    if (dout !== 8'h22 || {valid, overrun_err} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_same_clk: got dout=%h valid=%b ovr=%b required 22 1 0",
               dout, valid, overrun_err);
    end
    do_rd();
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = done_cnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    hold(1'b0, BIT_CLK);
    hold(1'b0, BIT_CLK * 4);
    hold(1'b1, 32);
    checks++;
    if (dut.state_q !== ST_DATA || dut.n_q !== 4'd4) begin
      errors++;
      $display("FAIL midreset_pre: got state=%0d n=%0d required %0d 4",
               dut.state_q, dut.n_q, ST_DATA);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({dout, valid, rx_done_tick, parity_err, frame_err, break_det, overrun_err} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got dout=%h flags=%b required all 0", dout,
               {valid, rx_done_tick, parity_err, frame_err, break_det, overrun_err});
    end
    hold(1'b1, BIT_CLK * 12);
    checks++;
    if (done_cnt - c0 !== 1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nodone: got pulses=%0d valid=%b required 1 0", done_cnt - c0, valid);
    end
    send_frame(8'h0F, 1'b0, 1'b1);
    checks++;
    if (dout !== 8'h0F || {valid, parity_err, frame_err, break_det, overrun_err} !== 5'b10000) begin
      errors++;
      $display("FAIL midreset_next: got dout=%h flags=%b required 0f 10000", dout,
               {valid, parity_err, frame_err, break_det, overrun_err});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_start_glitch();
    test_majority();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
